truth_table_sweeper: RTL and testbench

Sequential stimulus generator and response capture stage wrapped around a 3-input combinational function block, such as the F(x,y,z) exercise logic.
- Drives every input combination in ascending order and holds each one for a settle window.
- Samples the function output into a truth-table vector and checks it against a parameterised expected table.
- Replaces hand-written #5 stimulus sequences with a synthesizable, self-checking sweep.

---
 rtl/truth_table_sweeper_if.sv | 24 ++
 rtl/truth_table_sweeper.sv | 102 ++++++++++
 tb/tb_truth_table_sweeper.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_if.sv
// Handshake and result bundle between the truth-table sweeper and the block it exercises.
// master = sweeper side, slave = function-block / controller side.
interface truth_table_sweeper_if #(
  parameter int N_IN = 3
);
  logic                 start;
  logic [N_IN-1:0]      stim;
  logic                 f_in;
  logic                 busy;
  logic                 done;
  logic [2**N_IN-1:0]   captured;
  logic                 pass;
  logic [N_IN-1:0]      fail_idx;

  modport master (
    input  start, f_in,
    output stim, busy, done, captured, pass, fail_idx
  );

  modport slave (
    output start, f_in,
    input  stim, busy, done, captured, pass, fail_idx
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Steps a combinational block through every input combination, captures its truth table
// and compares it with EXPECTED. Optional macro SWEEP_ABORT_ON_FAIL_EN stops at the first mismatch.
module truth_table_sweeper #(
  parameter int                 N_IN     = 3,
  parameter int                 SETTLE   = 2,
  parameter logic [2**N_IN-1:0] EXPECTED = 8'h54
) (
  input  logic                  clk,
  input  logic                  rst,
  truth_table_sweeper_if.master bus
);

  localparam int              CW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   LAST_CNT  = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_STIM = '1;

  typedef enum logic [1:0] {IDLE, DRIVE, FINISH} state_t;

  state_t          state, next_state;
  logic [CW-1:0]   cnt;
  logic            fail_flag;
  logic            sample;
  logic            mismatch;
  logic            finishing;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // The sample edge is the last settle cycle of the current combination.
  always_comb begin
    next_state = state;
    sample     = 1'b0;
    mismatch   = 1'b0;
    finishing  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) next_state = DRIVE;
      end
      DRIVE: begin
        sample   = (cnt == LAST_CNT);
        mismatch = sample && (bus.f_in != EXPECTED[bus.stim]);
`ifdef SWEEP_ABORT_ON_FAIL_EN
        finishing = sample && ((bus.stim == LAST_STIM) || mismatch);
`else
        finishing = sample && (bus.stim == LAST_STIM);
`endif
        if (finishing) next_state = FINISH;
      end
      FINISH: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign bus.busy = (state == DRIVE);
  assign bus.done = (state == FINISH);

  // pass is resolved on the edge entering FINISH so it is already valid while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.stim     <= '0;
      bus.captured <= '0;
      bus.pass     <= 1'b0;
      bus.fail_idx <= '0;
      cnt          <= '0;
      fail_flag    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.stim     <= '0;
            bus.captured <= '0;
            bus.pass     <= 1'b0;
            bus.fail_idx <= '0;
            cnt          <= '0;
            fail_flag    <= 1'b0;
          end
        end
        DRIVE: begin
          if (sample) begin
            bus.captured[bus.stim] <= bus.f_in;
            if (mismatch && !fail_flag) begin
              fail_flag    <= 1'b1;
              bus.fail_idx <= bus.stim;
            end
            if (finishing) begin
              bus.pass <= !(fail_flag || mismatch);
            end else begin
              bus.stim <= bus.stim + 1'b1;
              cnt      <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: directed vectors, randomized response tables
// against a behavioural model, mid-sweep reset and a SETTLE=1 instance.
module tb_truth_table_sweeper;

  localparam int         N_IN   = 3;
  localparam int         SETTLE = 2;
  localparam logic [7:0] EXP    = 8'h54;
`ifdef SWEEP_ABORT_ON_FAIL_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic clk;
  logic rst;
  logic [7:0] resp_tbl;
  int total;
  int bad;

  truth_table_sweeper_if #(.N_IN(N_IN)) bus ();
  truth_table_sweeper_if #(.N_IN(N_IN)) bus1 ();

  truth_table_sweeper #(.N_IN(N_IN), .SETTLE(SETTLE), .EXPECTED(EXP)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  truth_table_sweeper #(.N_IN(N_IN), .SETTLE(1), .EXPECTED(EXP)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The function block under sweep is a lookup of the current response table.
  always_comb bus.f_in  = resp_tbl[bus.stim];
  always_comb bus1.f_in = EXP[bus1.stim];

  typedef struct {
    logic [7:0] resp;
    bit         poke;
    logic [7:0] tbl;
    bit         pass;
    logic [2:0] fidx;
    int         busy;
    logic [2:0] stim_end;
  } vec_t;

  vec_t vecs [5];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Reference: sample every combination in order, stopping after the first miss when aborting.
  function automatic void refSweep(input logic [7:0] resp, output logic [7:0] tbl, output bit ok,
                                   output logic [2:0] fidx, output int busy, output logic [2:0] stim_end);
    int first = -1;
    int n = 0;
    tbl = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (!(ABORT && first >= 0)) begin
        tbl[i] = resp[i];
        n++;
        if (resp[i] != EXP[i] && first < 0) first = i;
      end
    end
    ok       = (first < 0);
    fidx     = ok ? 3'd0 : 3'(first);
    busy     = n * SETTLE;
    stim_end = (ABORT && first >= 0) ? 3'(first) : 3'd7;
  endfunction

  task automatic applyStimulus(input vec_t v, input string tag);
    int  busy_cnt = 0;
    int  cyc = 0;
    bit  seq_ok = 1'b1;
    resp_tbl = v.resp;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (!bus.done && cyc < 100) begin
      if (bus.busy) begin
        if (bus.stim !== 3'(busy_cnt / SETTLE)) seq_ok = 1'b0;
        busy_cnt++;
      end
      bus.start = v.poke && (busy_cnt == 5);
      cyc++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    checkOutput({tag, " done_seen"}, 32'(bus.done), 32'd1);
    checkOutput({tag, " busy_cycles"}, 32'(busy_cnt), 32'(v.busy));
    checkOutput({tag, " stim_seq"}, 32'(seq_ok), 32'd1);
    checkOutput({tag, " table"}, 32'(bus.captured), 32'(v.tbl));
    checkOutput({tag, " pass"}, 32'(bus.pass), 32'(v.pass));
    checkOutput({tag, " fail_idx"}, 32'(bus.fail_idx), 32'(v.fidx));
    checkOutput({tag, " stim_end"}, 32'(bus.stim), 32'(v.stim_end));
    if (v.poke) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput({tag, " done_single"}, {31'd0, bus.done | bus.busy}, 32'd0);
    @(negedge clk);
    checkOutput({tag, " idle_after"}, {31'd0, bus.busy}, 32'd0);
    checkOutput({tag, " table_hold"}, 32'(bus.captured), 32'(v.tbl));
  endtask

  initial begin
    vec_t rv;
    int   cyc;
    int   busy1;
    bit   seq1;
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus1.start = 1'b0;
    resp_tbl  = 8'h00;

    vecs[0] = '{resp: 8'h54, poke: 1'b0, tbl: 8'h54, pass: 1'b1, fidx: 3'd0, busy: 16, stim_end: 3'd7};
    vecs[3] = '{resp: 8'h54, poke: 1'b1, tbl: 8'h54, pass: 1'b1, fidx: 3'd0, busy: 16, stim_end: 3'd7};
    if (ABORT) begin
      vecs[1] = '{resp: 8'h00, poke: 1'b0, tbl: 8'h00, pass: 1'b0, fidx: 3'd2, busy: 6,  stim_end: 3'd2};
      vecs[2] = '{resp: 8'h74, poke: 1'b0, tbl: 8'h34, pass: 1'b0, fidx: 3'd5, busy: 12, stim_end: 3'd5};
      vecs[4] = '{resp: 8'hFF, poke: 1'b0, tbl: 8'h01, pass: 1'b0, fidx: 3'd0, busy: 2,  stim_end: 3'd0};
    end else begin
      vecs[1] = '{resp: 8'h00, poke: 1'b0, tbl: 8'h00, pass: 1'b0, fidx: 3'd2, busy: 16, stim_end: 3'd7};
      vecs[2] = '{resp: 8'h74, poke: 1'b0, tbl: 8'h74, pass: 1'b0, fidx: 3'd5, busy: 16, stim_end: 3'd7};
      vecs[4] = '{resp: 8'hFF, poke: 1'b0, tbl: 8'hFF, pass: 1'b0, fidx: 3'd0, busy: 16, stim_end: 3'd7};
    end

    repeat (3) @(negedge clk);
    checkOutput("rst stim", 32'(bus.stim), 32'd0);
    checkOutput("rst busy", 32'(bus.busy), 32'd0);
    checkOutput("rst done", 32'(bus.done), 32'd0);
    checkOutput("rst table", 32'(bus.captured), 32'd0);
    checkOutput("rst pass", 32'(bus.pass), 32'd0);
    checkOutput("rst fail_idx", 32'(bus.fail_idx), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    for (int r = 0; r < 6; r++) begin
      rv.resp = 8'($urandom);
      rv.poke = 1'b0;
      refSweep(rv.resp, rv.tbl, rv.pass, rv.fidx, rv.busy, rv.stim_end);
      applyStimulus(rv, $sformatf("rand%0d", r));
    end

    // Reset in the middle of a sweep, then a clean sweep afterwards.
    resp_tbl = 8'h54;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (!(bus.busy && bus.stim == 3'd4) && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    checkOutput("midrst reached_stim4", 32'(bus.stim), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst stim", 32'(bus.stim), 32'd0);
    checkOutput("midrst busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst table", 32'(bus.captured), 32'd0);
    checkOutput("midrst pass_idx", {bus.pass, bus.fail_idx, bus.done}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midrst stays_idle", 32'(bus.busy), 32'd0);
    applyStimulus(vecs[0], "after_rst");

    // SETTLE=1 instance: stim advances every cycle.
    @(negedge clk);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    busy1 = 0;
    seq1  = 1'b1;
    cyc   = 0;
    while (!bus1.done && cyc < 100) begin
      if (bus1.busy) begin
        if (bus1.stim !== 3'(busy1)) seq1 = 1'b0;
        busy1++;
      end
      cyc++;
      @(negedge clk);
    end
    checkOutput("s1 done_seen", 32'(bus1.done), 32'd1);
    checkOutput("s1 busy_cycles", 32'(busy1), 32'd8);
    checkOutput("s1 stim_seq", 32'(seq1), 32'd1);
    checkOutput("s1 table", 32'(bus1.captured), 32'h54);
    checkOutput("s1 pass", 32'(bus1.pass), 32'd1);
    checkOutput("s1 fail_idx", 32'(bus1.fail_idx), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
